// File: rtl/dct_block_sequencer.sv
// Front-end sequencer for the 2-D DCT: buffers 8x8 raster blocks in a ping-pong
// store and issues each block to the x2z array as a gap-free 128-beat schedule.
module dct_block_sequencer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [DATA_WIDTH-1:0] o_x_data,
  output logic                  o_x_sum_diff_sel,
  output logic                  o_x_load,
  output logic                  o_x_valid,
  output logic                  o_blk_start,
  output logic                  o_blk_done,
  output logic                  o_busy
);

  localparam int unsigned BLK_PIX = 64;
  localparam int unsigned BEATS   = 128;
  localparam int unsigned AW      = 6;
  localparam int unsigned BW      = 7;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                r_state;
  logic [BW-1:0]         r_bc;
  logic                  r_rb;
  logic                  r_wb;
  logic [AW-1:0]         r_wr_addr;
  logic [1:0]            r_full;
  logic [DATA_WIDTH-1:0] r_mem [0:2*BLK_PIX-1];

  logic [DATA_WIDTH-1:0] r_x_data;
  logic                  r_x_sel;
  logic                  r_x_load;
  logic                  r_x_valid;
  logic                  r_blk_start;
  logic                  r_blk_done;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [BW-1:0]         w_bc_nxt;
  logic                  w_rb_nxt;
  logic [1:0]            w_full_set;
  logic [1:0]            w_full_clr;
  logic [1:0]            w_full_avail;
  logic                  w_wr_fire;
  logic                  w_wr_last;
  logic                  w_issue;
  logic [BW-1:0]         w_rd_addr;

  // Butterfly pairing order within a row: 0,7,1,6,2,5,3,4
  function automatic logic [2:0] f_pair_col(input logic [2:0] k);
    logic [2:0] half;
    half = {1'b0, k[2:1]};
    return k[0] ? (3'd7 - half) : half;
  endfunction

  assign o_in_ready = ~r_full[r_wb];
  assign w_wr_fire  = i_in_valid & ~r_full[r_wb];
  assign w_wr_last  = w_wr_fire & (r_wr_addr == AW'(BLK_PIX - 1));

  always_comb begin
    w_full_set        = '0;
    w_full_set[r_wb]  = w_wr_last;
  end

  // A block completing this very cycle counts as ready so back-to-back issue has no bubble
  assign w_full_avail = r_full | w_full_set;

  always_comb begin
    w_state_nxt = r_state;
    w_bc_nxt    = r_bc;
    w_rb_nxt    = r_rb;
    w_full_clr  = '0;
    case (r_state)
      S_IDLE: begin
        w_bc_nxt = '0;
        if (r_full[r_rb]) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_bc == BW'(BEATS - 1)) begin
          w_full_clr[r_rb] = 1'b1;
          w_rb_nxt         = ~r_rb;
          w_bc_nxt         = '0;
          if (!w_full_avail[~r_rb]) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_bc_nxt = r_bc + BW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bc_nxt    = '0;
      end
    endcase
    w_issue   = (w_state_nxt == S_ISSUE);
    w_rd_addr = {w_rb_nxt, w_bc_nxt[6:4], f_pair_col(w_bc_nxt[2:0])};
  end

  // Control and output registers; outputs carry the beat selected for the coming cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bc        <= '0;
      r_rb        <= 1'b0;
      r_wb        <= 1'b0;
      r_wr_addr   <= '0;
      r_full      <= '0;
      r_x_data    <= '0;
      r_x_sel     <= 1'b0;
      r_x_load    <= 1'b0;
      r_x_valid   <= 1'b0;
      r_blk_start <= 1'b0;
      r_blk_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bc        <= w_bc_nxt;
      r_rb        <= w_rb_nxt;
      r_full      <= (r_full | w_full_set) & ~w_full_clr;
      if (w_wr_fire) begin
        r_wr_addr <= r_wr_addr + AW'(1);
        if (w_wr_last) begin
          r_wb <= ~r_wb;
        end
      end
      r_x_data    <= w_issue ? r_mem[w_rd_addr] : '0;
      r_x_sel     <= w_issue & w_bc_nxt[3];
      r_x_load    <= w_issue & (w_bc_nxt[2:0] == 3'd0);
      r_x_valid   <= w_issue;
      r_blk_start <= w_issue & (w_bc_nxt == '0);
      r_blk_done  <= w_issue & (w_bc_nxt == BW'(BEATS - 1));
      r_busy      <= w_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_fire) begin
      r_mem[{r_wb, r_wr_addr}] <= i_in_data;
    end
  end

  assign o_x_data         = r_x_data;
  assign o_x_sum_diff_sel = r_x_sel;
  assign o_x_load         = r_x_load;
  assign o_x_valid        = r_x_valid;
  assign o_blk_start      = r_blk_start;
  assign o_blk_done       = r_blk_done;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Scoreboard bench for dct_block_sequencer: a block-level reference model predicts
// issue timing, beat contents and input backpressure from accepted pixels.
module tb_dct_block_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_in_data;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] o_x_data;
  logic       o_x_sum_diff_sel;
  logic       o_x_load;
  logic       o_x_valid;
  logic       o_blk_start;
  logic       o_blk_done;
  logic       o_busy;

  dct_block_sequencer #(.DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_in_data        (i_in_data),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .o_x_data         (o_x_data),
    .o_x_sum_diff_sel (o_x_sum_diff_sel),
    .o_x_load         (o_x_load),
    .o_x_valid        (o_x_valid),
    .o_blk_start      (o_blk_start),
    .o_blk_done       (o_blk_done),
    .o_busy           (o_busy)
  );

  typedef struct {
    logic [7:0] d;
    bit         sel;
    bit         load;
    bit         start;
    bit         done;
  } beat_t;

  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         last_start = -1000;
  int         la       = 0;
  int         pair [8] = '{0, 7, 1, 6, 2, 5, 3, 4};
  beat_t      exp_q [$];
  int         st_q  [$];
  logic [7:0] cur   [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s cycle %0d: event did not occur as required", name, cyc);
  endtask

  // Reference model: a block is issued at lastAccept+2, or directly after the
  // previous block if it completed no later than that block's final beat.
  always @(negedge clk) begin
    beat_t bt;
    bit    ev;
    int    s;
    if (!rst_n) begin
      exp_q.delete();
      st_q.delete();
      cur.delete();
      last_start = -1000;
    end else begin
      while (st_q.size() > 0 && cyc >= st_q[0] + 128) void'(st_q.pop_front());
      ev = (st_q.size() > 0) && (st_q[0] <= cyc);
      chk("in_ready", 32'(o_in_ready), 32'(st_q.size() < 2));
      chk("x_valid", 32'(o_x_valid), 32'(ev));
      chk("busy", 32'(o_busy), 32'(ev));
      if (o_x_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          bt = exp_q.pop_front();
          chk("x_data", 32'(o_x_data), 32'(bt.d));
          chk("x_sel", 32'(o_x_sum_diff_sel), 32'(bt.sel));
          chk("x_load", 32'(o_x_load), 32'(bt.load));
          chk("blk_start", 32'(o_blk_start), 32'(bt.start));
          chk("blk_done", 32'(o_blk_done), 32'(bt.done));
        end
      end else begin
        chk("idle_data", 32'(o_x_data), 32'(0));
        chk("idle_sel", 32'(o_x_sum_diff_sel), 32'(0));
        chk("idle_load", 32'(o_x_load), 32'(0));
        chk("idle_start", 32'(o_blk_start), 32'(0));
        chk("idle_done", 32'(o_blk_done), 32'(0));
      end
      if (i_in_valid && o_in_ready) begin
        cur.push_back(i_in_data);
        if (cur.size() == 64) begin
          s = (cyc <= last_start + 127) ? last_start + 128 : cyc + 2;
          last_start = s;
          st_q.push_back(s);
          for (int b = 0; b < 128; b++) begin
            bt.d     = cur[(b / 16) * 8 + pair[b % 8]];
            bt.sel   = ((b / 8) % 2) == 1;
            bt.load  = (b % 8) == 0;
            bt.start = (b == 0);
            bt.done  = (b == 127);
            exp_q.push_back(bt);
          end
          cur.delete();
        end
      end
    end
  end

  // Offer n pixels with pct% valid probability; ramp gives pixel value = index
  task automatic send(input int n, input int pct, input bit ramp);
    int         sent;
    int         budget;
    logic [7:0] d;
    sent   = 0;
    budget = 0;
    d      = ramp ? 8'(0) : 8'($urandom);
    while (sent < n && budget < 20000) begin
      i_in_valid = (int'($urandom_range(0, 99)) < pct);
      i_in_data  = d;
      @(negedge clk);
      if (i_in_valid && o_in_ready) begin
        sent++;
        la = cyc;
        d  = ramp ? 8'(sent) : 8'($urandom);
      end
      @(posedge clk); #1;
      budget++;
    end
    i_in_valid = 1'b0;
    if (sent < n) fail_now("send_budget");
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((st_q.size() != 0 || exp_q.size() != 0) && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 2000) fail_now("drain_timeout");
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    rst_n      = 1'b0;
    i_in_valid = 1'b0;
    i_in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // quiet after reset
    repeat (200) @(posedge clk);
    #1;

    // single ramp block, then idle
    send(64, 100, 1'b1);
    wait_drain();
    repeat (50) @(posedge clk);
    #1;

    // three blocks at full input rate
    send(192, 100, 1'b0);
    wait_drain();

    // four blocks with 50% valid
    send(256, 50, 1'b0);
    wait_drain();

    // next block completes on the beat-127 cycle of the current block
    send(64, 100, 1'b0);
    n0 = la;
    send(63, 100, 1'b0);
    wait_until(n0 + 129);
    send(1, 100, 1'b0);
    send(64, 100, 1'b0);
    wait_drain();

    // reset at beat 50 with a partial block written
    send(64, 100, 1'b0);
    n0 = la;
    send(30, 100, 1'b0);
    wait_until(n0 + 52);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(64, 100, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dct_block_sequencer.md
# dct_block_sequencer

Front-end controller for the 2-D DCT pipeline. It accepts 8x8 pixel blocks in raster order over a valid/ready stream and buffers them in a ping-pong store. It then drives the x2z systolic array input (data, sum/diff select, load) as a gap-free 128-beat schedule per block. It is the only producer of the x2z input stream and guarantees the continuous issue that the array's accumulators require.

## Interface
- DATA_WIDTH, 8, pixel width; also the width of x_data.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  DATA_WIDTH  pixel, raster order within the block (row 0 col 0..7, row 1, ...).
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer can accept a pixel; a transfer occurs when in_valid & in_ready.
- x_data  out  DATA_WIDTH  pixel to the x2z array.
- x_sum_diff_sel  out  1  0 = sum pass (even coefficients), 1 = difference pass (odd coefficients).
- x_load  out  1  first beat of a pass; restarts the PE accumulators.
- x_valid  out  1  beat valid.
- blk_start  out  1  one-cycle pulse coincident with beat 0 of a block.
- blk_done  out  1  one-cycle pulse coincident with beat 127 of a block.
- busy  out  1  high while the issue FSM is in ISSUE.

## Operation
- Storage: two banks of 64 x DATA_WIDTH. Per-bank full flag; write-bank pointer wb; read-bank pointer rb.
- Write side:
  - in_ready = ~full[wb].
  - Each transfer writes bank wb at wr_addr (0..63), then increments wr_addr.
  - On the transfer at wr_addr=63: set full[wb], toggle wb, and wrap wr_addr to 0.
- Issue FSM, states IDLE and ISSUE:
  - IDLE -> ISSUE when full[rb]=1.
  - In ISSUE the beat counter bc (0..127) advances every cycle with no stalls. No downstream backpressure exists.
- Beat decode:
  - row = bc[6:4]; pass = bc[3], which drives x_sum_diff_sel; k = bc[2:0].
  - Column order per pass is pairing order col(k) = 0,7,1,6,2,5,3,4 for k = 0..7.
  - x_data = bank[rb][row*8 + col(k)].
  - x_load = (k==0); x_valid = 1.
  - Each row is issued twice: the sum pass, then the diff pass. 16 beats per row, 128 per block.
- At bc=127:
  - Clear full[rb] and toggle rb.
  - If full[~rb] is already set (next block ready), stay in ISSUE with bc=0 and no bubble.
  - Otherwise go to IDLE.
- Outputs when not issuing: x_valid=0, x_load=0, x_sum_diff_sel=0, x_data=0.
- Write and read sides are independent. Setting full on one bank and clearing it on the other in the same cycle are both honoured.
- A bank is never written while full. The read bank is never released before beat 127.

## Timing
- All x_*, blk_*, and busy outputs are registered. in_ready is combinational from full[wb].
- Reset values:
  - in_ready=1, x_data=0, x_sum_diff_sel=0, x_load=0, x_valid=0, blk_start=0, blk_done=0, busy=0.
  - wb=rb=0, wr_addr=0, bc=0, full=00, FSM=IDLE.
- Latency: the 64th pixel is accepted in cycle N, full is visible in N+1, and beat 0 (x_valid, x_load, blk_start) appears in cycle N+2 when the FSM was IDLE.
- Beat 127 is cycle S+127 for beat 0 in cycle S. Back-to-back blocks give beat 0 of the next block in S+128.
- Bank release: full[rb] clears after the beat-127 edge, so in_ready can rise in cycle S+128 if that bank was blocking writes.
- Throughput: one block per 128 cycles sustained. Input needs 64 cycles, so in_ready deasserts periodically under full-rate input.
- Reset mid-operation: both banks are discarded and outputs return to reset values on the next cycle. A partially issued block is abandoned with no blk_done.

## Test plan
- Single block with p(r,c)=8r+c, then idle:
  - Beat 0 occurs 2 cycles after the last accept.
  - x_data for beats 0-7 is 0,7,1,6,2,5,3,4 with sel=0 and x_load on beat 0; beats 8-15 repeat with sel=1 and load on beat 8.
  - Beats 112-119 are 56,63,57,62,58,61,59,60.
  - blk_done on beat 127; x_valid=0 afterwards.
- Three blocks at full input rate with in_valid=1 constantly:
  - Beats run 384 cycles with no x_valid gap.
  - in_ready is low while both banks are full.
  - Total accepted is 192 pixels, with blk_start at S, S+128, S+256.
- Random in_valid (50%) across 4 blocks:
  - Issued data matches the raster-reordered input per block.
  - No beat is issued from a non-full bank.
- Second block completes on the same cycle block 1 issues beat 127:
  - Next block beat 0 follows with no bubble.
  - The released bank accepts writes starting the next cycle.
- rst_n low at beat 50 of a block and at wr_addr 30:
  - Next cycle all outputs are at reset values and in_ready=1.
  - A fresh 64-pixel block issues correctly with no stale data.
- Idle input for 200 cycles after reset: x_valid, busy, and blk_* stay 0 throughout.
